fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, SHALL set the redirect target on a misaligned-target trap.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 imm  in  32  SHALL be the branch/jal offset for the issued instruction.
REQ-006 cond  in  2  SHALL select the next PC: 00 sequential, 01 jal/taken branch, 1x jalr.
REQ-007 alu_out  in  32  SHALL be the jalr target.
REQ-008 core_ready  in  1  SHALL indicate the core accepts instr this cycle; cond, imm and alu_out are valid only then.
REQ-009 imem_req  out  1  SHALL request a fetch.
REQ-010 imem_addr  out  32  SHALL carry the fetch address, stable while imem_req=1.
REQ-011 imem_gnt  in  1  SHALL accept the request.
REQ-012 imem_rvalid  in  1  SHALL flag returned data.
REQ-013 imem_rdata  in  32  SHALL carry the fetched word.
REQ-014 instr_valid  out  1  SHALL flag a held instruction.
REQ-015 instr  out  32  SHALL carry the held instruction word.
REQ-016 pc  out  32  SHALL carry the address of the held or in-flight instruction.
REQ-017 pc_plus4  out  32  SHALL equal pc+4 combinationally (link value).
REQ-018 misalign_trap  out  1  SHALL pulse when a misaligned target is rejected.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT and ISSUE.
- IDLE: one cycle, then REQ.
- REQ: imem_req=1, imem_addr=pc; imem_gnt moves to WAIT.
- WAIT: imem_rvalid moves to ISSUE and latches imem_rdata into instr.
- ISSUE: instr_valid=1; on core_ready, update pc and move to REQ.
REQ-020 Only one fetch SHALL be outstanding; imem_req SHALL be 0 outside REQ.
REQ-021 imem_rvalid SHALL be ignored in IDLE, REQ and ISSUE.
REQ-022 imem_rvalid arriving in the cycle after imem_gnt SHALL be accepted, giving a 2-cycle REQ-to-ISSUE minimum.
REQ-023 The next-PC target on acceptance SHALL be:
- cond 00: pc+4.
- cond 01: pc+imm.
- cond 1x: {alu_out[31:1],1'b0}.
REQ-024 Target arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 yields 32'h0000_0000.
REQ-025 Without core_ready in ISSUE, instr, pc and instr_valid SHALL hold unchanged indefinitely.
REQ-026 imm, alu_out and cond SHALL be sampled only on the ISSUE && core_ready cycle.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 and misalign_trap=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the outstanding fetch; a late imem_rvalid SHALL be discarded per REQ-021.
REQ-029 The first imem_req SHALL assert in the cycle following the first rising edge with rst_n high.

Configuration
REQ-030 Macro FETCH_CTRL_MISALIGN_TRAP_EN, when defined, SHALL check the REQ-023 target:
- if target[1]=1, set pc=TRAP_VEC instead;
- pulse misalign_trap for exactly the cycle after acceptance;
- then fetch from TRAP_VEC.
REQ-031 With the macro undefined, the REQ-023 target SHALL be used unmodified and misalign_trap SHALL be tied 0.

Verification
REQ-032 Reset release, imem_gnt in REQ, imem_rvalid next cycle with rdata=32'h0000_0013, core_ready=1, cond=00 -> addresses 0x0, then 0x4; instr=32'h0000_0013.
REQ-033 ISSUE at pc=0x100, cond=01, imm=32'hFFFF_FFF0 -> next imem_addr=0xF0; imm=0x20 -> 0x120.
REQ-034 cond=10, alu_out=0x2001 -> next imem_addr=0x2000.
REQ-035 Macro defined, cond=10, alu_out=0x2002 -> one-cycle misalign_trap, next imem_addr=0x100. Macro undefined -> imem_addr=0x2002, no trap.
REQ-036 core_ready low 5 cycles in ISSUE -> instr and pc stable, imem_req=0. rst_n low during WAIT, then rvalid after release -> rvalid ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// fetch_ctrl : single-outstanding instruction fetch controller with PC update
// Optional macro FETCH_CTRL_MISALIGN_TRAP_EN redirects misaligned targets.
// Revision 1.0
// ------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imm,
  input  logic [1:0]  cond,
  input  logic [31:0] alu_out,
  input  logic        core_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] target;
  logic        target_bad;
  logic [31:0] redirect;
  logic        trap_nxt;

  assign pc_plus4    = pc + 32'd4;
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);

  always_comb begin
    target = pc_plus4;
    case (cond)
      2'b00:   target = pc_plus4;
      2'b01:   target = pc + imm;
      default: target = {alu_out[31:1], 1'b0};
    endcase
  end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  assign target_bad = target[1];
`else
  assign target_bad = 1'b0;
`endif

  assign redirect = target_bad ? TRAP_VEC : target;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    trap_nxt  = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = ISSUE;
          instr_nxt = imem_rdata;
        end
      end
      ISSUE: begin
        // cond/imm/alu_out are only meaningful on the accepting cycle
        if (core_ready) begin
          state_nxt = REQ;
          pc_nxt    = redirect;
          trap_nxt  = target_bad;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
    end
  end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_nxt;
  end

  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// Testbench for fetch_ctrl: directed scenarios plus randomized memory/core
// traffic checked against a transaction-level model of the fetch loop.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imm = '0;
  logic [1:0]  cond = '0;
  logic [31:0] alu_out = '0;
  logic        core_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .imm(imm), .cond(cond), .alu_out(alu_out),
    .core_ready(core_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: a fetch is either awaiting grant, granted (outstanding) or held
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_instr = '0;
  logic        outstanding = 1'b0;
  logic        holding = 1'b0;
  logic        exp_trap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic cr, input logic [1:0] cnd,
                      input logic [31:0] im, input logic [31:0] alu);
    logic        in_req;
    logic [31:0] tgt;
    logic        nt;
    @(negedge clk);
    in_req = !outstanding && !holding;
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, holding});
    if (holding) chk("instr", instr, exp_instr);
    chk("imem_req", {31'd0, imem_req}, {31'd0, in_req});
    if (in_req) chk("imem_addr", imem_addr, exp_pc);
    chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, exp_trap});
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    core_ready = cr; cond = cnd; imm = im; alu_out = alu;
    nt = 1'b0;
    if (in_req) begin
      if (g) outstanding = 1'b1;
    end else if (outstanding) begin
      if (rv) begin
        outstanding = 1'b0;
        holding = 1'b1;
        exp_instr = rd;
      end
    end else if (holding && cr) begin
      if (cnd == 2'b00)      tgt = exp_pc + 32'd4;
      else if (cnd == 2'b01) tgt = exp_pc + im;
      else                   tgt = alu & 32'hFFFF_FFFE;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      if (tgt[1]) begin
        tgt = TRAP_VEC;
        nt = 1'b1;
      end
`endif
      exp_pc = tgt;
      holding = 1'b0;
    end
    exp_trap = nt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
    exp_pc = RESET_PC; outstanding = 1'b0; holding = 1'b0; exp_trap = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] data);
    step(1'b1, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0);
    step(1'b0, 1'b1, data, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic issue(input logic [1:0] cnd, input logic [31:0] im, input logic [31:0] alu);
    step(1'b0, 1'b0, 32'd0, 1'b1, cnd, im, alu);
  endtask

  initial begin
    logic [31:0] r_imm;
    do_reset();
    idle();
    chk("first_addr", imem_addr, RESET_PC);
    fetch(32'h0000_0013);
    idle();
    chk("instr_13", instr, 32'h0000_0013);
    issue(2'b00, 32'd0, 32'd0);
    idle();
    chk("seq_addr", imem_addr, 32'h4);

    fetch(32'h1111_1111); issue(2'b01, 32'hFC, 32'd0); idle();
    chk("jal_to_100", imem_addr, 32'h100);
    fetch(32'h2222_2222); issue(2'b01, 32'hFFFF_FFF0, 32'd0); idle();
    chk("jal_neg", imem_addr, 32'hF0);
    fetch(32'h3333_3333); issue(2'b10, 32'd0, 32'h100); idle();
    fetch(32'h4444_4444); issue(2'b01, 32'h20, 32'd0); idle();
    chk("jal_pos", imem_addr, 32'h120);
    fetch(32'h5555_5555); issue(2'b10, 32'd0, 32'h2001); idle();
    chk("jalr_lsb", imem_addr, 32'h2000);

    fetch(32'h6666_6666); issue(2'b11, 32'd0, 32'h2002); idle();
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    chk("trap_pulse", {31'd0, misalign_trap}, 32'd1);
    chk("trap_addr", imem_addr, TRAP_VEC);
    idle();
    chk("trap_clear", {31'd0, misalign_trap}, 32'd0);
`else
    chk("no_trap", {31'd0, misalign_trap}, 32'd0);
    chk("misaligned_addr", imem_addr, 32'h2002);
`endif

    fetch(32'h7777_7777); issue(2'b10, 32'd0, 32'hFFFF_FFFC); idle();
    fetch(32'h8888_8888); issue(2'b00, 32'd0, 32'd0); idle();
    chk("wrap_addr", imem_addr, 32'h0);

    fetch(32'h9999_9999);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'hBAD0_0000, 1'b0, 2'b01, 32'h40, 32'h80);
    chk("stall_instr", instr, 32'h9999_9999);
    chk("stall_pc", pc, 32'h0);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    issue(2'b00, 32'd0, 32'd0);

    step(1'b1, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0);
    do_reset();
    idle();
    chk("restart_addr", imem_addr, RESET_PC);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r_imm = $urandom;
        if ($urandom_range(0, 3) != 0) r_imm[1:0] = 2'b00;
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), r_imm, $urandom);
      end
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
